// File: rtl/modbus_frame_rx.sv
// rtl/modbus_frame_rx.sv - Modbus RTU frame receiver with T1.5 gap and T3.5 delimiter timing
// Optional station-address filter enabled by defining MODBUS_ADDR_FILTER_EN.
module modbus_frame_rx #(
  parameter logic [15:0] T15_CYCLES = 16'd573,
  parameter logic [15:0] T35_CYCLES = 16'd1337,
  parameter logic [7:0]  SLAVE_ADDR = 8'h01
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [7:0]  rx_byte,
  input  logic        rx_byte_valid,
  output logic [47:0] frame_data,
  output logic [15:0] frame_crc,
  output logic        rx_message_done,
  output logic        frame_err,
  output logic [1:0]  err_code
);

`ifdef MODBUS_ADDR_FILTER_EN
  localparam bit ADDR_FILTER = 1'b1;
`else
  localparam bit ADDR_FILTER = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_STARTUP,
    ST_IDLE,
    ST_RECEIVE,
    ST_DROP,
    ST_PUBLISH
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] idle_cnt;
  logic [3:0]  byte_cnt;
  logic        gap_flag;
  logic        long_flag;
  logic [7:0]  byte_buf [8];

  logic        t35_silent;
  logic        start_byte;
  logic        addr_ok;
  logic        frame_bad;
  logic [1:0]  err_code_nxt;
  logic        publish_now;
  logic        discard_now;

  // A strobe always wins over the delimiter: silence only counts with no byte present.
  assign t35_silent = (idle_cnt == T35_CYCLES) && !rx_byte_valid;
  assign addr_ok    = !ADDR_FILTER || (rx_byte == SLAVE_ADDR) || (rx_byte == 8'h00);
  assign start_byte = rx_byte_valid && addr_ok &&
                      ((state == ST_IDLE) || (state == ST_PUBLISH));

  assign frame_bad    = gap_flag || long_flag || (byte_cnt < 4'd8);
  assign err_code_nxt = gap_flag ? 2'b11 : (long_flag ? 2'b10 : 2'b01);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      idle_cnt <= '0;
    end else if (rx_byte_valid) begin
      idle_cnt <= '0;
    end else if (idle_cnt != T35_CYCLES) begin
      idle_cnt <= idle_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= ST_STARTUP;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_STARTUP: begin
        if (t35_silent) state_nxt = ST_IDLE;
      end
      ST_IDLE, ST_PUBLISH: begin
        if (rx_byte_valid) begin
          state_nxt = addr_ok ? ST_RECEIVE : ST_DROP;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_RECEIVE: begin
        if (t35_silent) state_nxt = frame_bad ? ST_IDLE : ST_PUBLISH;
      end
      ST_DROP: begin
        if (t35_silent) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_STARTUP;
    endcase
  end

  always_comb begin
    publish_now = 1'b0;
    discard_now = 1'b0;
    case (state)
      ST_PUBLISH: publish_now = 1'b1;
      ST_RECEIVE: discard_now = t35_silent && frame_bad;
      default: begin
        publish_now = 1'b0;
        discard_now = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      byte_cnt  <= '0;
      gap_flag  <= 1'b0;
      long_flag <= 1'b0;
    end else if (start_byte) begin
      byte_cnt  <= 4'd1;
      gap_flag  <= 1'b0;
      long_flag <= 1'b0;
    end else if ((state == ST_RECEIVE) && rx_byte_valid) begin
      if (idle_cnt >= T15_CYCLES) gap_flag <= 1'b1;
      if (byte_cnt < 4'd8) begin
        byte_cnt <= byte_cnt + 4'd1;
      end else begin
        long_flag <= 1'b1;
        byte_cnt  <= 4'd9;
      end
    end
  end

  // Buffer holds no state that matters outside a frame, so it is left unreset.
  always_ff @(posedge clk_in) begin
    if (start_byte) begin
      byte_buf[0] <= rx_byte;
    end else if ((state == ST_RECEIVE) && rx_byte_valid && (byte_cnt < 4'd8)) begin
      byte_buf[byte_cnt[2:0]] <= rx_byte;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      frame_data      <= '0;
      frame_crc       <= '0;
      rx_message_done <= 1'b0;
      frame_err       <= 1'b0;
      err_code        <= 2'b00;
    end else begin
      rx_message_done <= publish_now;
      frame_err       <= discard_now;
      if (publish_now) begin
        frame_data <= {byte_buf[0], byte_buf[1], byte_buf[2],
                       byte_buf[3], byte_buf[4], byte_buf[5]};
        frame_crc  <= {byte_buf[7], byte_buf[6]};
      end
      if (discard_now) begin
        err_code <= err_code_nxt;
      end
    end
  end

endmodule

// File: tb/tb_modbus_frame_rx.sv
// tb/tb_modbus_frame_rx.sv - scoreboard bench for modbus_frame_rx
// Honours MODBUS_ADDR_FILTER_EN for the address-filter cases.
module tb_modbus_frame_rx;

  localparam int T35 = 35;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_byte_valid = 1'b0;
  logic [47:0] frame_data;
  logic [15:0] frame_crc;
  logic        rx_message_done;
  logic        frame_err;
  logic [1:0]  err_code;

  modbus_frame_rx #(
    .T15_CYCLES(16'd15),
    .T35_CYCLES(16'd35),
    .SLAVE_ADDR(8'h01)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .rx_byte(rx_byte),
    .rx_byte_valid(rx_byte_valid),
    .frame_data(frame_data),
    .frame_crc(frame_crc),
    .rx_message_done(rx_message_done),
    .frame_err(frame_err),
    .err_code(err_code)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    bit          is_err;
    logic [1:0]  code;
    logic [47:0] data;
    logic [15:0] crc;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          last_strobe = 0;
  logic [47:0] cur_data = '0;
  logic [15:0] cur_crc = '0;
  logic [1:0]  cur_code = 2'b00;
  logic [7:0]  fr [10];

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk_in) begin
    if (!rst_in && (rx_message_done || frame_err)) begin
      chk("pulse_exclusive", {63'd0, rx_message_done && frame_err}, 64'd0);
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pulse: got done=%0b err=%0b expected none (cycle %0d)",
                 rx_message_done, frame_err, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pulse_kind", {63'd0, frame_err}, {63'd0, e.is_err});
        chk("pulse_cycle", 64'(cyc), 64'(e.cyc));
        chk("frame_data", {16'd0, frame_data}, {16'd0, e.data});
        chk("frame_crc", {48'd0, frame_crc}, {48'd0, e.crc});
        chk("err_code", {62'd0, err_code}, {62'd0, e.code});
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk_in);
  endtask

  task automatic strobe(input logic [7:0] b, input int wait_cycles);
    repeat (wait_cycles) @(posedge clk_in);
    #1;
    rx_byte       = b;
    rx_byte_valid = 1'b1;
    last_strobe   = cyc + 1;
    @(posedge clk_in);
    #1;
    rx_byte_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_frame_data", {16'd0, frame_data}, 64'd0);
    chk("rst_frame_crc", {48'd0, frame_crc}, 64'd0);
    chk("rst_done", {63'd0, rx_message_done}, 64'd0);
    chk("rst_err", {63'd0, frame_err}, 64'd0);
    chk("rst_err_code", {62'd0, err_code}, 64'd0);
    cur_data = '0;
    cur_crc  = '0;
    cur_code = 2'b00;
    rst_in   = 1'b0;
  endtask

  // kind: 0 = no pulse expected, 1 = publish, 2 = discard with code
  task automatic send_frame(input int n, input int gap_idx, input int gap_w,
                            input int kind, input logic [1:0] code);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      strobe(fr[i], (i == gap_idx) ? gap_w : 9);
    end
    if (kind == 1) begin
      cur_data = {fr[0], fr[1], fr[2], fr[3], fr[4], fr[5]};
      cur_crc  = {fr[7], fr[6]};
      e.is_err = 1'b0;
      e.cyc    = last_strobe + T35 + 2;
    end else if (kind == 2) begin
      cur_code = code;
      e.is_err = 1'b1;
      e.cyc    = last_strobe + T35 + 1;
    end
    e.code = cur_code;
    e.data = cur_data;
    e.crc  = cur_crc;
    if (kind != 0) sb.push_back(e);
  endtask

  initial begin
    fr = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A, 8'h55, 8'h66};
    do_reset();
    idle(40);
    send_frame(8, -1, 0, 1, 2'b00);
    idle(50);
    chk("t1_data_const", {16'd0, frame_data}, {16'd0, 48'h010300000001});
    chk("t1_crc_const", {48'd0, frame_crc}, {48'd0, 16'h0A84});

    send_frame(8, 4, 19, 2, 2'b11);
    idle(50);
    send_frame(7, -1, 0, 2, 2'b01);
    idle(50);
    send_frame(9, -1, 0, 2, 2'b10);
    idle(50);
    send_frame(9, 2, 19, 2, 2'b11);
    idle(50);
    // Byte 7 strobed as the counter would hit T3.5: still part of the frame, gap flagged.
    send_frame(8, 7, 34, 2, 2'b11);
    idle(50);
    send_frame(8, 3, 15, 2, 2'b11);
    idle(50);

    fr = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA};
    send_frame(8, 3, 14, 1, 2'b00);
    idle(50);

    do_reset();
    fr = '{8'h01, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03, 8'h98, 8'h0B, 8'h00, 8'h00};
    send_frame(8, -1, 0, 0, 2'b00);
    idle(50);
    send_frame(8, -1, 0, 1, 2'b00);
    idle(50);

    fr = '{8'h01, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h00, 8'h00};
    send_frame(4, -1, 0, 0, 2'b00);
    do_reset();
    idle(40);
    send_frame(8, -1, 0, 1, 2'b00);
    idle(50);

    fr = '{8'h05, 8'h03, 8'h00, 8'h10, 8'h00, 8'h02, 8'hC5, 8'hCE, 8'h00, 8'h00};
`ifdef MODBUS_ADDR_FILTER_EN
    send_frame(8, -1, 0, 0, 2'b00);
    idle(50);
    fr[0] = 8'h00;
    send_frame(8, -1, 0, 1, 2'b00);
`else
    send_frame(8, -1, 0, 1, 2'b00);
`endif
    idle(50);

    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk_in);
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL missing_pulse: got %0d outstanding expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/modbus_frame_rx.md
MODBUS_FRAME_RX -- requirements
Module: modbus_frame_rx

Interface
REQ-001 SHALL have parameter T15_CYCLES, default 16'd573: clock cycles equal to 1.5 character times (inter-byte gap limit).
REQ-002 SHALL have parameter T35_CYCLES, default 16'd1337: clock cycles equal to 3.5 character times (frame delimiter); T35_CYCLES > T15_CYCLES >= 2.
REQ-003 SHALL have parameter SLAVE_ADDR, default 8'h01: own station address.
REQ-004 SHALL have port clk_in, input, 1: system clock; one clock domain only.
REQ-005 SHALL have port rst_in, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port rx_byte, input, 8: byte from the UART receiver.
REQ-007 SHALL have port rx_byte_valid, input, 1: one-cycle strobe qualifying rx_byte.
REQ-008 SHALL have port frame_data, output, 48: bytes 0..5 of the frame; byte 0 (first received) in [47:40], byte 5 in [7:0]; feeds the CRC stage data_in.
REQ-009 SHALL have port frame_crc, output, 16: received CRC; [7:0] = byte 6, [15:8] = byte 7, so it compares directly with the CRC stage result.
REQ-010 SHALL have port rx_message_done, output, 1: one-cycle pulse when a valid 8-byte frame is published.
REQ-011 SHALL have port frame_err, output, 1: one-cycle pulse when a frame is discarded.
REQ-012 SHALL have port err_code, output, 2: cause of the last discard; 01 short, 10 long, 11 gap; held until the next discard.

Function
REQ-013 SHALL keep a 16-bit idle counter: cleared in any cycle with rx_byte_valid=1, otherwise incremented, saturating at T35_CYCLES.
REQ-014 SHALL implement states STARTUP, IDLE, RECEIVE, DROP, PUBLISH.
REQ-015 STARTUP: bytes discarded; go to IDLE in the cycle after the idle counter reaches T35_CYCLES.
REQ-016 IDLE: rx_byte_valid stores the byte as byte 0, sets byte count to 1, and goes to RECEIVE.
REQ-017 RECEIVE: each strobe stores the byte at index = byte count and increments the count.
REQ-018 RECEIVE: a strobe arriving after the idle counter has reached T15_CYCLES (and before T35_CYCLES) sets a gap flag; reception continues.
REQ-019 RECEIVE: a 9th byte sets a long flag; further bytes are ignored; the count saturates at 9.
REQ-020 RECEIVE: when the idle counter reaches T35_CYCLES with rx_byte_valid=0, the frame ends.
REQ-021 Frame-end priority: gap beats long; long beats short (count < 8).
REQ-022 Frame-end with no error and count = 8: go to PUBLISH.
REQ-023 Frame-end with any error: pulse frame_err the next cycle, load err_code, return to IDLE; frame_data and frame_crc stay unchanged.
REQ-024 PUBLISH (one cycle): load frame_data and frame_crc from the byte buffer, pulse rx_message_done, return to IDLE.
REQ-025 Total latency: rx_message_done rises exactly T35_CYCLES+2 clocks after the strobe of byte 7.
REQ-026 frame_data and frame_crc SHALL update only in PUBLISH and SHALL remain stable until the next PUBLISH.
REQ-027 A strobe in the same cycle the idle counter would reach T35_CYCLES SHALL take priority: the byte belongs to the current frame and the end is not declared.
REQ-028 rx_message_done and frame_err SHALL never be high in the same cycle.
REQ-029 DROP: silent discard; waits for a T35_CYCLES gap, then goes to IDLE; no pulses are issued.

Reset
REQ-030 While rst_in=1 at a clk_in edge, the block SHALL enter STARTUP and clear the idle counter, byte count and flags.
REQ-031 While rst_in=1 at a clk_in edge, frame_data=0, frame_crc=0, rx_message_done=0, frame_err=0 and err_code=0.
REQ-032 Reset mid-frame SHALL abandon the partial frame without any pulse.
REQ-033 After reset, the block SHALL require a full T35_CYCLES silence before accepting a frame.

Configuration
REQ-034 With macro MODBUS_ADDR_FILTER_EN defined: a frame ending without error whose byte 0 is neither SLAVE_ADDR nor 8'h00 SHALL NOT publish or pulse frame_err.
REQ-035 With MODBUS_ADDR_FILTER_EN defined: the address check SHALL happen at byte 0 reception; on mismatch, go to DROP.
REQ-036 Without MODBUS_ADDR_FILTER_EN: every error-free 8-byte frame SHALL publish regardless of byte 0.

Verification
Benches use T15_CYCLES=15, T35_CYCLES=35, and bytes spaced 10 cycles unless stated.
REQ-037 Reset, 40 idle cycles, bytes 01 03 00 00 00 01 84 0A -> one rx_message_done at T35+2 after the last byte; frame_data=48'h010300000001; frame_crc=16'h0A84.
REQ-038 Same frame with a 20-cycle gap before byte 4 -> frame_err pulse with err_code=11; no rx_message_done; frame_data unchanged.
REQ-039 Seven bytes -> err_code=01; nine bytes -> err_code=10; nine bytes with a 20-cycle gap -> err_code=11.
REQ-040 Bytes strobed within 35 cycles of reset -> discarded; a frame after 35+ silent cycles publishes normally.
REQ-041 rst_in asserted after byte 3, then a full valid frame -> only the second frame publishes.
REQ-042 MODBUS_ADDR_FILTER_EN defined, byte 0 = 8'h05 -> no pulses; byte 0 = 8'h00 -> rx_message_done pulses; filter off, byte 0 = 8'h05 -> rx_message_done pulses.
